sram_access_arbiter: RTL and testbench
======================================

// Module: sram_access_arbiter
// PURPOSE
//  Sequences every access to the shared single-port 16-bit SRAM.
//  Arbitrates between two requesters: the CPU memory port (MAR/MDR path driven by
//  the ISDU) and the program-loader port (used to fill memory before Run).
//  Inserts a programmable number of wait states per access, replacing hard-coded
//  memory wait states in the control FSM with a req/ack handshake.
// PARAMETERS
//  ADDR_W       20  SRAM address width
//  DATA_W       16  SRAM data width
//  WAIT_STATES  2   extra SRAM cycles per access (0..15); ACCESS lasts WAIT_STATES+1 cycles
// PORTS
//  Clk          in   1       system clock, all logic on rising edge
//  Reset        in   1       synchronous, active-high
//  cpu_req      in   1       CPU access request; hold with fields stable until cpu_ack
//  cpu_we       in   1       1 = write, 0 = read
//  cpu_addr     in   ADDR_W  CPU address
//  cpu_wdata    in   DATA_W  CPU write data
//  cpu_ack      out  1       1-cycle pulse: CPU access complete
//  cpu_rdata    out  DATA_W  last CPU read data, held until next CPU read completes
//  ldr_req      in   1       loader access request (same rules as cpu_req)
//  ldr_we       in   1       1 = write, 0 = read
//  ldr_addr     in   ADDR_W  loader address
//  ldr_wdata    in   DATA_W  loader write data
//  ldr_ack      out  1       1-cycle pulse: loader access complete
//  ldr_rdata    out  DATA_W  last loader read data, held
//  sram_ce_n    out  1       SRAM chip enable, active low
//  sram_oe_n    out  1       SRAM output enable, active low
//  sram_we_n    out  1       SRAM write enable, active low
//  sram_addr    out  ADDR_W  SRAM address (registered)
//  sram_dq_out  out  DATA_W  write data to tristate buffer
//  sram_dq_oe   out  1       1 = drive sram_dq_out onto DQ bus
//  sram_dq_in   in   DATA_W  DQ bus read value
//  busy         out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, ce_n/oe_n/we_n=1, dq_oe=0, acks=0, addr/dq_out/rdata=0,
//   last_grant=LDR (first tie goes to CPU). Reset mid-access aborts at next edge, no ack.
//  FSM: IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE: if any req, grant; both req -> grant the requester != last_grant; update
//   last_grant; register addr, we, wdata of winner; load wait counter with WAIT_STATES.
//  ACCESS: ce_n=0; read: oe_n=0, dq_oe=0; write: we_n=0, dq_oe=1, dq_out=wdata.
//   Counter decrements each cycle; at counter==0 a read captures sram_dq_in into the
//   winner's rdata and state -> DONE.
//  DONE: ce_n/oe_n/we_n=1, dq_oe=0, sram_addr held (address hold after WE rise);
//   winner's ack=1 for this single cycle; -> IDLE.
//  Latency: grant in cycle N -> ack in cycle N+WAIT_STATES+2; back-to-back
//   throughput one access per WAIT_STATES+3 cycles.
//  Requester must drop req on the edge where it samples ack; req still high in the
//   following IDLE is a new request.
//  req dropped during ACCESS: access still completes and ack is still pulsed.
//  Request fields changed after grant: ignored (registered copy used).
//  Writes never modify rdata; cpu_ack and ldr_ack are never high together.
//  Loser of a tie keeps req high and is granted at the next IDLE (no starvation).
// TESTING
//  CPU read, WAIT_STATES=2, addr 0x00010, SRAM model 0x1234 -> ack 4 cycles after grant, cpu_rdata=0x1234.
//  Loader write 0xBEEF @0x00020 -> we_n low 3 cycles, dq_oe=1, ldr_ack once, then CPU read 0x00020 returns 0xBEEF.
//  Both req in same IDLE after reset -> CPU served first, loader next; alternate on continued ties.
//  cpu_req dropped in 2nd ACCESS cycle -> access completes, cpu_ack pulses once, no new grant.
//  Reset asserted during ACCESS of a write -> next cycle we_n=1, ce_n=1, no ack, state IDLE.
//  WAIT_STATES=0 -> ACCESS 1 cycle, ack at grant+2, read data correct.

Source files
------------

// File: rtl/sram_access_arbiter_if.sv
// Request/acknowledge bundle for the two SRAM requesters plus the SRAM pin group.
// The master side is the requester/board; the slave side is the arbiter.
interface sram_access_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_ack;
    logic [DATA_W-1:0] ldr_rdata;

    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_out;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_in;
    logic              busy;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_ack, ldr_rdata,
        input  sram_ce_n, sram_oe_n, sram_we_n,
        input  sram_addr, sram_dq_out, sram_dq_oe,
        output sram_dq_in,
        input  busy
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_ack, ldr_rdata,
        output sram_ce_n, sram_oe_n, sram_we_n,
        output sram_addr, sram_dq_out, sram_dq_oe,
        input  sram_dq_in,
        output busy
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// Single-port SRAM sequencer: round-robin CPU/loader arbitration,
// programmable wait states, one-cycle ack pulse per completed access.
module sram_access_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 2
) (
    input logic                 Clk,
    input logic                 Reset,
    sram_access_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_LDR = 1'b1
    } gnt_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t            state;
    state_t            state_nx;
    gnt_t              last_grant;
    logic [3:0]        cnt;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] dq_r;
    logic [DATA_W-1:0] cpu_rd_r;
    logic [DATA_W-1:0] ldr_rd_r;
    logic              any_req;
    logic              pick_ldr;

    assign any_req = bus.cpu_req | bus.ldr_req;

    // On a tie the requester that was not served last wins.
    assign pick_ldr = bus.ldr_req &
                      (~bus.cpu_req | (last_grant == GNT_CPU));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        bus.sram_ce_n   = 1'b1;
        bus.sram_oe_n   = 1'b1;
        bus.sram_we_n   = 1'b1;
        bus.sram_dq_oe  = 1'b0;
        bus.cpu_ack     = 1'b0;
        bus.ldr_ack     = 1'b0;
        bus.busy        = 1'b1;
        unique case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (any_req) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                bus.sram_ce_n  = 1'b0;
                bus.sram_oe_n  = we_r;
                bus.sram_we_n  = ~we_r;
                bus.sram_dq_oe = we_r;
                if (cnt == 4'd0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                bus.cpu_ack = (last_grant == GNT_CPU);
                bus.ldr_ack = (last_grant == GNT_LDR);
                state_nx    = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_grant <= GNT_LDR;
            cnt        <= 4'd0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            dq_r       <= '0;
            cpu_rd_r   <= '0;
            ldr_rd_r   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        cnt <= WS;
                        if (pick_ldr) begin
                            last_grant <= GNT_LDR;
                            we_r       <= bus.ldr_we;
                            addr_r     <= bus.ldr_addr;
                            dq_r       <= bus.ldr_wdata;
                        end else begin
                            last_grant <= GNT_CPU;
                            we_r       <= bus.cpu_we;
                            addr_r     <= bus.cpu_addr;
                            dq_r       <= bus.cpu_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!we_r && last_grant == GNT_CPU) begin
                            cpu_rd_r <= bus.sram_dq_in;
                        end
                        if (!we_r && last_grant == GNT_LDR) begin
                            ldr_rd_r <= bus.sram_dq_in;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sram_addr   = addr_r;
    assign bus.sram_dq_out = dq_r;
    assign bus.cpu_rdata   = cpu_rd_r;
    assign bus.ldr_rdata   = ldr_rd_r;
endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench: two arbiters (2 and 0 wait states), each on its own
// behavioural SRAM, driven from a vector table plus corner-case sequences.
module tb_sram_access_arbiter;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    sram_access_arbiter_if #(.ADDR_W(20), .DATA_W(16)) ia ();
    sram_access_arbiter_if #(.ADDR_W(20), .DATA_W(16)) ib ();

    sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_STATES(2)) dut_a (
        .Clk(Clk), .Reset(Reset), .bus(ia)
    );
    sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_STATES(0)) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(ib)
    );

    logic        dsel = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [19:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        ldr_req = 1'b0, ldr_we = 1'b0;
    logic [19:0] ldr_addr = '0;
    logic [15:0] ldr_wdata = '0;

    assign ia.cpu_req   = cpu_req & ~dsel;
    assign ib.cpu_req   = cpu_req & dsel;
    assign ia.ldr_req   = ldr_req & ~dsel;
    assign ib.ldr_req   = ldr_req & dsel;
    assign ia.cpu_we    = cpu_we;
    assign ib.cpu_we    = cpu_we;
    assign ia.cpu_addr  = cpu_addr;
    assign ib.cpu_addr  = cpu_addr;
    assign ia.cpu_wdata = cpu_wdata;
    assign ib.cpu_wdata = cpu_wdata;
    assign ia.ldr_we    = ldr_we;
    assign ib.ldr_we    = ldr_we;
    assign ia.ldr_addr  = ldr_addr;
    assign ib.ldr_addr  = ldr_addr;
    assign ia.ldr_wdata = ldr_wdata;
    assign ib.ldr_wdata = ldr_wdata;

    // Behavioural SRAMs; 0x10 is preloaded with 0x1234 while in reset.
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];

    always @(posedge Clk) begin
        if (Reset) begin
            mem_a[8'h10] <= 16'h1234;
        end else if (!ia.sram_ce_n && !ia.sram_we_n && ia.sram_dq_oe) begin
            mem_a[ia.sram_addr[7:0]] <= ia.sram_dq_out;
        end
    end

    always @(posedge Clk) begin
        if (Reset) begin
            mem_b[8'h10] <= 16'h1234;
        end else if (!ib.sram_ce_n && !ib.sram_we_n && ib.sram_dq_oe) begin
            mem_b[ib.sram_addr[7:0]] <= ib.sram_dq_out;
        end
    end

    assign ia.sram_dq_in = (!ia.sram_ce_n && !ia.sram_oe_n) ?
                           mem_a[ia.sram_addr[7:0]] : 16'hDEAD;
    assign ib.sram_dq_in = (!ib.sram_ce_n && !ib.sram_oe_n) ?
                           mem_b[ib.sram_addr[7:0]] : 16'hDEAD;

    logic        m_cpu_ack, m_ldr_ack, m_ce_n, m_oe_n, m_we_n, m_dq_oe, m_busy;
    logic [15:0] m_cpu_rdata, m_ldr_rdata;

    assign m_cpu_ack   = dsel ? ib.cpu_ack   : ia.cpu_ack;
    assign m_ldr_ack   = dsel ? ib.ldr_ack   : ia.ldr_ack;
    assign m_ce_n      = dsel ? ib.sram_ce_n : ia.sram_ce_n;
    assign m_oe_n      = dsel ? ib.sram_oe_n : ia.sram_oe_n;
    assign m_we_n      = dsel ? ib.sram_we_n : ia.sram_we_n;
    assign m_dq_oe     = dsel ? ib.sram_dq_oe : ia.sram_dq_oe;
    assign m_busy      = dsel ? ib.busy      : ia.busy;
    assign m_cpu_rdata = dsel ? ib.cpu_rdata : ia.cpu_rdata;
    assign m_ldr_rdata = dsel ? ib.ldr_rdata : ia.ldr_rdata;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called right after a negedge with the arbiter idle. Ack is expected
    // at the (WAIT_STATES+2)th negedge; strobe counts ACCESS-cycle strobes.
    task automatic run_access(input bit use_ldr, input bit we,
                              input logic [19:0] addr, input logic [15:0] wd,
                              output int lat, output int strobe,
                              output int ackc);
        bit own;
        lat = -1;
        strobe = 0;
        ackc = 0;
        if (use_ldr) begin
            ldr_we = we; ldr_addr = addr; ldr_wdata = wd; ldr_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            if (we ? (!m_ce_n && !m_we_n && m_dq_oe)
                   : (!m_ce_n && !m_oe_n && !m_dq_oe))
                strobe++;
            own = use_ldr ? m_ldr_ack : m_cpu_ack;
            if (use_ldr ? m_cpu_ack : m_ldr_ack) ackc += 100;
            if (own) begin
                ackc++;
                lat = k;
                break;
            end
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        @(negedge Clk);
        if (m_cpu_ack || m_ldr_ack) ackc++;
    endtask

    typedef struct {
        bit          ldr;
        bit          we;
        logic [19:0] addr;
        logic [15:0] wd;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vt [7];

    initial begin
        int lat, strobe, ackc;
        int nack, bsy, acnt;
        logic [3:0] ord;
        int pos [4];
        bit both;

        vt[0] = '{1'b1, 1'b1, 20'h00020, 16'hBEEF, 16'h1234};
        vt[1] = '{1'b0, 1'b0, 20'h00010, 16'h0000, 16'h1234};
        vt[2] = '{1'b0, 1'b0, 20'h00020, 16'h0000, 16'hBEEF};
        vt[3] = '{1'b0, 1'b1, 20'h00030, 16'hA5A5, 16'hBEEF};
        vt[4] = '{1'b1, 1'b0, 20'h00030, 16'h0000, 16'hA5A5};
        vt[5] = '{1'b0, 1'b1, 20'h00010, 16'h5678, 16'hBEEF};
        vt[6] = '{1'b1, 1'b0, 20'h00010, 16'h0000, 16'h5678};

        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("reset busy", 32'(ia.busy), 32'd0);
        chk("reset ce_n/oe_n/we_n", 32'({ia.sram_ce_n, ia.sram_oe_n, ia.sram_we_n}), 32'h7);
        chk("reset dq_oe", 32'(ia.sram_dq_oe), 32'd0);
        chk("reset acks", 32'({ia.cpu_ack, ia.ldr_ack}), 32'd0);
        chk("reset addr", 32'(ia.sram_addr), 32'd0);
        chk("reset dq_out", 32'(ia.sram_dq_out), 32'd0);
        chk("reset rdata", 32'({ia.cpu_rdata, ia.ldr_rdata}), 32'd0);

        // Continuous ties: CPU first after reset, then strict alternation.
        cpu_we = 1'b0; cpu_addr = 20'h00010;
        ldr_we = 1'b0; ldr_addr = 20'h00010;
        cpu_req = 1'b1; ldr_req = 1'b1;
        nack = 0; ord = '0; both = 1'b0;
        pos[0] = 0; pos[1] = 0; pos[2] = 0; pos[3] = 0;
        for (int k = 1; k <= 40 && nack < 4; k++) begin
            @(negedge Clk);
            if (m_cpu_ack && m_ldr_ack) both = 1'b1;
            if (m_cpu_ack || m_ldr_ack) begin
                ord[nack] = m_ldr_ack;
                pos[nack] = k;
                nack++;
            end
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        @(negedge Clk);
        chk("tie ack count", 32'(nack), 32'd4);
        chk("tie order", 32'(ord), 32'hA);
        chk("tie first latency", 32'(pos[0]), 32'd4);
        chk("tie throughput", 32'(pos[3]), 32'd19);
        chk("tie both acks", 32'(both), 32'd0);
        chk("tie rdata", 32'({m_cpu_rdata, m_ldr_rdata}), 32'h12341234);

        for (int i = 0; i < 7; i++) begin
            run_access(vt[i].ldr, vt[i].we, vt[i].addr, vt[i].wd,
                       lat, strobe, ackc);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
            chk($sformatf("vec%0d strobes", i), 32'(strobe), 32'd3);
            chk($sformatf("vec%0d acks", i), 32'(ackc), 32'd1);
            chk($sformatf("vec%0d rdata", i),
                32'(vt[i].ldr ? m_ldr_rdata : m_cpu_rdata), 32'(vt[i].exp_rd));
        end

        // Req dropped in 2nd ACCESS cycle; address also changed after grant.
        cpu_we = 1'b0; cpu_addr = 20'h00020; cpu_req = 1'b1;
        acnt = 0; bsy = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge Clk);
            if (k == 2) begin
                cpu_req = 1'b0;
                cpu_addr = 20'h00010;
            end
            if (m_cpu_ack) acnt++;
            if (m_busy) bsy++;
        end
        chk("drop ack count", 32'(acnt), 32'd1);
        chk("drop busy cycles", 32'(bsy), 32'd4);
        chk("drop rdata", 32'(m_cpu_rdata), 32'hBEEF);

        // Reset during a write access.
        cpu_we = 1'b1; cpu_addr = 20'h00040; cpu_wdata = 16'h1111; cpu_req = 1'b1;
        @(negedge Clk);
        chk("rst pre we_n", 32'(m_we_n), 32'd0);
        Reset = 1'b1;
        @(negedge Clk);
        chk("rst we_n/ce_n", 32'({m_we_n, m_ce_n}), 32'h3);
        chk("rst busy/dq_oe", 32'({m_busy, m_dq_oe}), 32'd0);
        Reset = 1'b0;
        cpu_req = 1'b0;
        acnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            if (m_cpu_ack || m_ldr_ack) acnt++;
        end
        chk("rst no ack", 32'(acnt), 32'd0);

        // Zero wait states.
        dsel = 1'b1;
        @(negedge Clk);
        run_access(1'b1, 1'b1, 20'h00050, 16'hCAFE, lat, strobe, ackc);
        chk("ws0 wr latency", 32'(lat), 32'd2);
        chk("ws0 wr strobes", 32'(strobe), 32'd1);
        chk("ws0 wr acks", 32'(ackc), 32'd1);
        run_access(1'b0, 1'b0, 20'h00050, 16'h0000, lat, strobe, ackc);
        chk("ws0 rd latency", 32'(lat), 32'd2);
        chk("ws0 rd strobes", 32'(strobe), 32'd1);
        chk("ws0 rd acks", 32'(ackc), 32'd1);
        chk("ws0 rd data", 32'(m_cpu_rdata), 32'hCAFE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
